// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags a channel once it has been stalled
// for STALL_LIMIT consecutive cycles and latches the first channel to block.
module axis_stall_detector #(
    parameter int unsigned       N_CH        = 2,
    parameter logic [N_CH-1:0]   RD_MASK     = N_CH'(1),
    parameter int unsigned       STALL_LIMIT = 1024,
    parameter int unsigned       CNT_W       = $clog2(STALL_LIMIT + 1),
    parameter int unsigned       IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [N_CH-1:0]   ch_tvalid,
    input  logic [N_CH-1:0]   ch_tready,
    output logic [N_CH-1:0]   axis_block_sigs,
    output logic              any_block,
    output logic              first_block_valid,
    output logic [IDX_W-1:0]  first_block_idx,
    output logic [31:0]       first_block_cycle
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CAPTURED = 1'b1
    } state_t;

    logic [N_CH-1:0][CNT_W-1:0] r_cnt;
    logic [31:0]                r_cycle;
    logic [IDX_W-1:0]           r_idx;
    logic [31:0]                r_cap_cycle;
    state_t                     r_state;
    state_t                     w_next_state;
    logic [N_CH-1:0]            w_stall;
    logic [N_CH-1:0]            w_entering;
    logic [IDX_W-1:0]           w_first_idx;
    logic                       w_capture;

    // Read-side ports stall when starved, write-side ports when backpressured.
    always_comb begin
        w_stall    = '0;
        w_entering = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_stall[i]    = RD_MASK[i] ? (ch_tready[i] & ~ch_tvalid[i])
                                       : (ch_tvalid[i] & ~ch_tready[i]);
            w_entering[i] = enable & w_stall[i] & (r_cnt[i] == LIMIT_M1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (clear || !enable) begin
                    r_cnt[i] <= '0;
                end else if (w_stall[i]) begin
                    if (r_cnt[i] != LIMIT) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle <= '0;
        end else if (clear) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    always_comb begin
        axis_block_sigs = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            axis_block_sigs[i] = (r_cnt[i] == LIMIT);
        end
    end

    assign any_block = |axis_block_sigs;

    // Scan downwards so the lowest entering channel wins.
    always_comb begin
        w_first_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (w_entering[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_capture) w_next_state = ST_CAPTURED;
            ST_CAPTURED: if (clear)     w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        first_block_valid = (r_state == ST_CAPTURED);
        w_capture         = (r_state == ST_IDLE) && !clear && (|w_entering);
    end

    // Capture uses the cycle count before this edge's increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_cap_cycle <= '0;
        end else if (clear) begin
            r_idx       <= '0;
            r_cap_cycle <= '0;
        end else if (w_capture) begin
            r_idx       <= w_first_idx;
            r_cap_cycle <= r_cycle;
        end
    end

    assign first_block_idx   = r_idx;
    assign first_block_cycle = r_cap_cycle;

endmodule
